// File: rtl/nand3_stim_pkg.sv
// Shared types and helpers for the NAND3 stimulus/checker block.
package nand3_stim_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int NUM_VEC = 8;

  function automatic logic exp_nand3(input logic [2:0] vec);
    return ~(&vec);
  endfunction

endpackage

// File: rtl/nand3_stim_chk_if.sv
// Pin bundle between the NAND3 checker (slave) and the bench/cell side (master).
interface nand3_stim_chk_if #(parameter int ERR_W = 4);
  logic             start;
  logic             A1;
  logic             A2;
  logic             A3;
  logic             ZN;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic [2:0]       fail_vec;

  modport master (
    output start, ZN,
    input  A1, A2, A3, busy, done, pass, err_cnt, fail_vec
  );

  modport slave (
    input  start, ZN,
    output A1, A2, A3, busy, done, pass, err_cnt, fail_vec
  );
endinterface

// File: rtl/nand3_stim_sync.sv
// Two-flop synchronizer for an asynchronous ZN return path; resets to 1.
module nand3_stim_sync (
  input  logic CLK,
  input  logic RN,
  input  logic d,
  output logic q
);
  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/nand3_stim_chk.sv
// Exhaustive NAND3 driver/checker: sweeps {A3,A2,A1} 000..111, samples ZN after a settle window.
// Optional NAND3_STIM_SYNC_EN inserts a 2-flop ZN synchronizer and stretches the window by 2.
module nand3_stim_chk
  import nand3_stim_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 4,
  parameter int LOOPS         = 1
) (
  input logic              CLK,
  input logic              RN,
  nand3_stim_chk_if.slave  bus
);

`ifdef NAND3_STIM_SYNC_EN
  localparam int SYNC_DLY = 2;
`else
  localparam int SYNC_DLY = 0;
`endif
  localparam logic [4:0] CNT_LOAD = 5'(SETTLE_CYCLES - 1 + SYNC_DLY);
  localparam logic [7:0] LAST_LOOP = 8'(LOOPS - 1);
  localparam logic [2:0] LAST_VEC = 3'(NUM_VEC - 1);

  logic zn_cmp;

`ifdef NAND3_STIM_SYNC_EN
  nand3_stim_sync u_sync (
    .CLK (CLK),
    .RN  (RN),
    .d   (bus.ZN),
    .q   (zn_cmp)
  );
`else
  assign zn_cmp = bus.ZN;
`endif

  state_e           state_d, state_q;
  logic [2:0]       vec_d, vec_q;
  logic [7:0]       loop_d, loop_q;
  logic [4:0]       cnt_d, cnt_q;
  logic             busy_d, busy_q;
  logic             done_d, done_q;
  logic             pass_d, pass_q;
  logic [ERR_W-1:0] err_d, err_q;
  logic [2:0]       fail_d, fail_q;
  logic             mismatch;

  // Case-inequality so an X/Z return counts as a failure in simulation.
  assign mismatch = (zn_cmp !== exp_nand3(vec_q));

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    loop_d  = loop_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fail_d  = fail_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          vec_d   = '0;
          loop_d  = '0;
          err_d   = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = SAMPLE;
        else             cnt_d   = cnt_q - 5'd1;
      end
      SAMPLE: begin
        // err_q==0 identifies the first mismatch: the counter saturates and never wraps.
        if (mismatch) begin
          if (err_q != '1) err_d = err_q + ERR_W'(1);
          if (err_q == '0) fail_d = vec_q;
        end
        if (vec_q != LAST_VEC) begin
          vec_d   = vec_q + 3'd1;
          cnt_d   = CNT_LOAD;
          state_d = SETTLE;
        end else if (loop_q < LAST_LOOP) begin
          vec_d   = '0;
          loop_d  = loop_q + 8'd1;
          cnt_d   = CNT_LOAD;
          state_d = SETTLE;
        end else begin
          vec_d   = '0;
          loop_d  = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      vec_q   <= '0;
      loop_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      loop_q  <= loop_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign bus.A1       = vec_q[0];
  assign bus.A2       = vec_q[1];
  assign bus.A3       = vec_q[2];
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.err_cnt  = err_q;
  assign bus.fail_vec = fail_q;

endmodule

// File: tb/tb_nand3_stim_chk.sv
// Bench for nand3_stim_chk: a fault-mask NAND3 model on ZN, reference results from mask arithmetic.
module tb_nand3_stim_chk;

  localparam int SETTLE = 2;
`ifdef NAND3_STIM_SYNC_EN
  localparam int PER = SETTLE + 3;
`else
  localparam int PER = SETTLE + 1;
`endif
  localparam int LAT1 = 8 * 1 * PER;
  localparam int LAT2 = 8 * 2 * PER;

  logic CLK = 1'b0;
  logic RN;
  logic [7:0] mask1 = 8'h00;
  logic [7:0] mask2 = 8'h00;
  int vecs = 0;
  int errs = 0;

  always #5 CLK = ~CLK;

  nand3_stim_chk_if #(.ERR_W(4)) bus1 ();
  nand3_stim_chk_if #(.ERR_W(2)) bus2 ();

  // Cell model: ideal NAND3 with a per-vector inversion mask modelling defects.
  assign bus1.ZN = ~(bus1.A1 & bus1.A2 & bus1.A3) ^ mask1[{bus1.A3, bus1.A2, bus1.A1}];
  assign bus2.ZN = ~(bus2.A1 & bus2.A2 & bus2.A3) ^ mask2[{bus2.A3, bus2.A2, bus2.A1}];

  nand3_stim_chk #(.SETTLE_CYCLES(SETTLE), .ERR_W(4), .LOOPS(1)) dut (
    .CLK (CLK),
    .RN  (RN),
    .bus (bus1)
  );

  nand3_stim_chk #(.SETTLE_CYCLES(SETTLE), .ERR_W(2), .LOOPS(2)) dut2 (
    .CLK (CLK),
    .RN  (RN),
    .bus (bus2)
  );

  task automatic test_reset();
    RN = 1'b1;
    bus1.start = 1'b0;
    bus2.start = 1'b0;
    #2 RN = 1'b0;
    #2;
    vecs++;
    if ({bus1.A3, bus1.A2, bus1.A1, bus1.busy, bus1.done, bus1.pass, bus1.err_cnt, bus1.fail_vec} !== 13'b0) begin
      errs++;
      $display("FAIL reset_dut1 got A=%b busy=%b done=%b pass=%b err=%0d fv=%b want all zero",
               {bus1.A3, bus1.A2, bus1.A1}, bus1.busy, bus1.done, bus1.pass, bus1.err_cnt, bus1.fail_vec);
    end
    vecs++;
    if ({bus2.A3, bus2.A2, bus2.A1, bus2.busy, bus2.done, bus2.pass, bus2.err_cnt, bus2.fail_vec} !== 11'b0) begin
      errs++;
      $display("FAIL reset_dut2 got A=%b busy=%b done=%b err=%0d fv=%b want all zero",
               {bus2.A3, bus2.A2, bus2.A1}, bus2.busy, bus2.done, bus2.err_cnt, bus2.fail_vec);
    end
    repeat (3) @(posedge CLK);
    @(negedge CLK) RN = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  // One LOOPS=1 sweep on dut; pulse_at>=0 raises start for one cycle mid-sweep (must be ignored).
  task automatic sweep1(input logic [7:0] mask, input int pulse_at, input string tag);
    int xerr;
    logic [2:0] xfv;
    bit found;
    logic [2:0] xa;
    mask1 = mask;
    xerr = 0;
    xfv = 3'd0;
    found = 1'b0;
    for (int v = 0; v < 8; v++) begin
      if (mask[v]) begin
        xerr++;
        if (!found) begin
          xfv = 3'(v);
          found = 1'b1;
        end
      end
    end
    if (xerr > 15) xerr = 15;
    @(negedge CLK) bus1.start = 1'b1;
    @(posedge CLK);
    #1 bus1.start = 1'b0;
    for (int e = 0; e <= LAT1; e++) begin
      if (e > 0) begin
        @(posedge CLK);
        #1;
      end
      xa = (e < LAT1) ? 3'((e / PER) % 8) : 3'd0;
      vecs++;
      if ({bus1.A3, bus1.A2, bus1.A1} !== xa || bus1.busy !== (e < LAT1) || bus1.done !== (e == LAT1)) begin
        errs++;
        $display("FAIL %s_seq edge=%0d got A=%b busy=%b done=%b want A=%b busy=%b done=%b",
                 tag, e, {bus1.A3, bus1.A2, bus1.A1}, bus1.busy, bus1.done, xa, e < LAT1, e == LAT1);
      end
      bus1.start = (e == pulse_at);
    end
    bus1.start = 1'b0;
    vecs++;
    if (bus1.err_cnt !== 4'(xerr) || bus1.fail_vec !== xfv || bus1.pass !== (xerr == 0)) begin
      errs++;
      $display("FAIL %s_result mask=%h got err=%0d fv=%b pass=%b want err=%0d fv=%b pass=%b",
               tag, mask, bus1.err_cnt, bus1.fail_vec, bus1.pass, xerr, xfv, xerr == 0);
    end
  endtask

  task automatic test_ideal();
    sweep1(8'h00, -1, "ideal");
  endtask

  task automatic test_stuck1();
    sweep1(8'h80, -1, "stuck1");
  endtask

  task automatic test_stuck0();
    sweep1(8'h7F, -1, "stuck0");
  endtask

  task automatic test_ignore_start();
    sweep1(8'h00, 9, "midstart");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      sweep1(8'($urandom), $urandom_range(0, LAT1 - 1), "rand");
    end
  endtask

  task automatic test_async_reset();
    mask1 = 8'h00;
    @(negedge CLK) bus1.start = 1'b1;
    @(posedge CLK);
    #1 bus1.start = 1'b0;
    repeat (10) @(posedge CLK);
    #2 RN = 1'b0;
    #1;
    vecs++;
    if ({bus1.A3, bus1.A2, bus1.A1, bus1.busy, bus1.done, bus1.pass, bus1.err_cnt, bus1.fail_vec} !== 13'b0) begin
      errs++;
      $display("FAIL async_reset got A=%b busy=%b done=%b pass=%b err=%0d fv=%b want all zero",
               {bus1.A3, bus1.A2, bus1.A1}, bus1.busy, bus1.done, bus1.pass, bus1.err_cnt, bus1.fail_vec);
    end
    @(negedge CLK) RN = 1'b1;
    @(negedge CLK);
    sweep1(8'h00, -1, "postreset");
  endtask

  // dut2: start held high, two loops, stuck-at-0 so the 2-bit counter saturates.
  task automatic test_back_to_back();
    bit seen;
    mask2 = 8'h7F;
    @(negedge CLK) bus2.start = 1'b1;
    @(posedge CLK);
    for (int e = 1; e <= LAT2 + 1; e++) begin
      @(posedge CLK);
      #1;
      if (e < LAT2) begin
        vecs++;
        if (bus2.done !== 1'b0 || bus2.busy !== 1'b1) begin
          errs++;
          $display("FAIL b2b_busy edge=%0d got done=%b busy=%b want done=0 busy=1", e, bus2.done, bus2.busy);
        end
      end else if (e == LAT2) begin
        vecs++;
        if (bus2.done !== 1'b1 || bus2.busy !== 1'b0 || bus2.err_cnt !== 2'd3 ||
            bus2.fail_vec !== 3'd0 || bus2.pass !== 1'b0) begin
          errs++;
          $display("FAIL b2b_done got done=%b busy=%b err=%0d fv=%b pass=%b want 1 0 3 000 0",
                   bus2.done, bus2.busy, bus2.err_cnt, bus2.fail_vec, bus2.pass);
        end
      end else begin
        vecs++;
        if (bus2.done !== 1'b0 || bus2.busy !== 1'b1 || bus2.err_cnt !== 2'd0 || bus2.fail_vec !== 3'd0) begin
          errs++;
          $display("FAIL b2b_restart got done=%b busy=%b err=%0d fv=%b want 0 1 0 000",
                   bus2.done, bus2.busy, bus2.err_cnt, bus2.fail_vec);
        end
      end
    end
    bus2.start = 1'b0;
    mask2 = 8'h00;
    seen = 1'b0;
    for (int e = 1; e <= LAT2 + 4 && !seen; e++) begin
      @(posedge CLK);
      #1;
      if (bus2.done === 1'b1) begin
        seen = 1'b1;
        vecs++;
        if (e != LAT2 || bus2.pass !== 1'b1 || bus2.err_cnt !== 2'd0) begin
          errs++;
          $display("FAIL b2b_second got edge=%0d pass=%b err=%0d want edge=%0d pass=1 err=0",
                   e, bus2.pass, bus2.err_cnt, LAT2);
        end
      end
    end
    if (!seen) begin
      vecs++;
      errs++;
      $display("FAIL b2b_timeout got done=%b want done=1 within %0d edges", bus2.done, LAT2 + 4);
    end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_stuck1();
    test_stuck0();
    test_ignore_start();
    test_random();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
